// File: rtl/wb_stage_buffered_if.sv
// ============================================================================
// Module : wb_stage_buffered_if
// Brief  : Upstream capture, register-file write and forwarding signals.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_stage_buffered_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_we;
  logic [ADDR_W-1:0]         in_dest;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_SRC*DATA_W-1:0] in_src;
  logic                      rf_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_dest;
  logic [DATA_W-1:0]         rf_data;
  logic                      fwd_valid;
  logic [ADDR_W-1:0]         fwd_dest;
  logic [DATA_W-1:0]         fwd_data;

  modport master (
    output in_valid, in_we, in_dest, in_sel, in_src, rf_ready,
    input  in_ready, rf_we, rf_dest, rf_data, fwd_valid, fwd_dest, fwd_data
  );

  modport slave (
    input  in_valid, in_we, in_dest, in_sel, in_src, rf_ready,
    output in_ready, rf_we, rf_dest, rf_data, fwd_valid, fwd_dest, fwd_data
  );
endinterface

`default_nettype wire

// File: rtl/wb_stage_buffered.sv
// ============================================================================
// Module : wb_stage_buffered
// Brief  : Write-back stage with result mux, 2-entry buffer and forwarding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage_buffered #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_SRC  = 2,
  parameter int SEL_W    = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  wb_stage_buffered_if.slave   bus
);

  localparam logic [1:0] c_cnt_full = 2'd2;

  // Slot 0 is always the head; a pop shifts slot 1 down.
  logic [1:0]        count_q, count_d;
  logic [1:0]        we_q, we_d;
  logic [ADDR_W-1:0] dest_q [2];
  logic [ADDR_W-1:0] dest_d [2];
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];

  logic [DATA_W-1:0] sel_data;
  logic              we_eff;
  logic              ready;
  logic              push;
  logic              pop;
  logic              has_head;
  logic [1:0]        wr_idx;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(bus.in_sel) == k) begin
        sel_data = bus.in_src[k*DATA_W +: DATA_W];
      end
    end
  end

  assign we_eff   = bus.in_we && !((ZERO_REG != 0) && (bus.in_dest == '0));
  assign ready    = !rst && !flush && (count_q != c_cnt_full);
  assign push     = bus.in_valid && ready;
  assign has_head = !rst && (count_q != 2'd0);
  assign pop      = has_head && !flush && (!we_q[0] || bus.rf_ready);
  assign wr_idx   = count_q - {1'b0, pop};

  always_comb begin
    count_d = count_q;
    we_d    = we_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (flush) begin
      count_d = 2'd0;
      we_d    = 2'b00;
    end else begin
      if (pop) begin
        we_d[0]   = we_q[1];
        dest_d[0] = dest_q[1];
        data_d[0] = data_q[1];
        we_d[1]   = 1'b0;
      end
      if (push) begin
        we_d[wr_idx[0]]   = we_eff;
        dest_d[wr_idx[0]] = bus.in_dest;
        data_d[wr_idx[0]] = sel_data;
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      we_q    <= 2'b00;
      dest_q  <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      count_q <= count_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.rf_we    = has_head && we_q[0] && !flush;
  assign bus.rf_dest  = has_head ? dest_q[0] : '0;
  assign bus.rf_data  = has_head ? data_q[0] : '0;

  // Tail is younger than head, so it wins when both carry a write.
  always_comb begin
    bus.fwd_valid = 1'b0;
    bus.fwd_dest  = '0;
    bus.fwd_data  = '0;
    if (!rst) begin
      if ((count_q == c_cnt_full) && we_q[1]) begin
        bus.fwd_valid = 1'b1;
        bus.fwd_dest  = dest_q[1];
        bus.fwd_data  = data_q[1];
      end else if ((count_q != 2'd0) && we_q[0]) begin
        bus.fwd_valid = 1'b1;
        bus.fwd_dest  = dest_q[0];
        bus.fwd_data  = data_q[0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_buffered.sv
// ============================================================================
// Module : tb_wb_stage_buffered
// Brief  : Queue-model scoreboard bench for wb_stage_buffered (3 sources).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_buffered;

  typedef struct {
    logic        we;
    logic [2:0]  dest;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  ent_t mb[$];      // buffered entries, oldest first
  ent_t exp_wr[$];  // register-file writes still owed

  always #5 clk = ~clk;

  wb_stage_buffered_if #(.DATA_W(16), .ADDR_W(3), .NUM_SRC(3), .SEL_W(2)) bus ();

  wb_stage_buffered #(
    .DATA_W(16), .ADDR_W(3), .NUM_SRC(3), .SEL_W(2), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int          sz;
    logic        fv;
    logic [2:0]  fd;
    logic [15:0] fdat;
    sz = mb.size();
    fv = 1'b0; fd = '0; fdat = '0;
    if (!rst) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (mb[i].we && !fv) begin
          fv = 1'b1; fd = mb[i].dest; fdat = mb[i].data;
        end
      end
    end
    chk("in_ready", 32'(bus.in_ready), 32'(!rst && !flush && sz < 2));
    if (!rst && sz > 0) begin
      chk("rf_we",   32'(bus.rf_we),   32'(!flush && mb[0].we));
      chk("rf_dest", 32'(bus.rf_dest), 32'(mb[0].dest));
      chk("rf_data", 32'(bus.rf_data), 32'(mb[0].data));
    end else begin
      chk("rf_we",   32'(bus.rf_we),   32'd0);
      chk("rf_dest", 32'(bus.rf_dest), 32'd0);
      chk("rf_data", 32'(bus.rf_data), 32'd0);
    end
    chk("fwd_valid", 32'(bus.fwd_valid), 32'(fv));
    chk("fwd_dest",  32'(bus.fwd_dest),  32'(fd));
    chk("fwd_data",  32'(bus.fwd_data),  32'(fdat));
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] d,
                       input logic [1:0] s, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic rdy, input logic fl,
                       input logic rs);
    @(negedge clk);
    rst          = rs;
    flush        = fl;
    bus.in_valid = v;
    bus.in_we    = we;
    bus.in_dest  = d;
    bus.in_sel   = s;
    bus.in_src   = {a2, a1, a0};
    bus.rf_ready = rdy;
    #1;
    model_check();
  endtask

  task automatic tick();
    ent_t        e;
    logic [15:0] src [3];
    logic        acc;
    @(posedge clk);
    if (rst || flush) begin
      mb.delete();
      exp_wr.delete();
    end else begin
      acc = bus.in_valid && (mb.size() < 2);
      if (mb.size() > 0 && (!mb[0].we || bus.rf_ready)) mb.delete(0);
      if (acc) begin
        src[0] = bus.in_src[15:0];
        src[1] = bus.in_src[31:16];
        src[2] = bus.in_src[47:32];
        e.we   = bus.in_we && (bus.in_dest != 3'd0);
        e.dest = bus.in_dest;
        e.data = (bus.in_sel < 2'd3) ? src[bus.in_sel] : 16'h0000;
        mb.push_back(e);
        if (e.we) exp_wr.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic we, input logic [2:0] d,
                     input logic [1:0] s, input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] a2, input logic rdy, input logic fl,
                     input logic rs);
    drive(v, we, d, s, a0, a1, a2, rdy, fl, rs);
    tick();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, rdy, 0, 0);
  endtask

  // Write monitor: every accepted register-file write must match the oldest owed one.
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (bus.rf_we === 1'b1 && bus.rf_ready === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_unexpected: got write dest=%0d data=0x%0h, expected none at %0t",
                 bus.rf_dest, bus.rf_data, $time);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_dest", 32'(bus.rf_dest), 32'(e.dest));
        chk("wr_data", 32'(bus.rf_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_we = 1'b0; bus.in_dest = '0;
    bus.in_sel = '0; bus.in_src = '0; bus.rf_ready = 1'b0;

    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1, 1);

    // Single write, one-cycle latency
    cyc(1, 1, 3, 1, 16'h0, 16'h1234, 16'h0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_we", 32'(bus.rf_we), 32'd1);
    chk("t1_dest", 32'(bus.rf_dest), 32'd3);
    chk("t1_data", 32'(bus.rf_data), 32'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_we_after", 32'(bus.rf_we), 32'd0);
    chk("t1_fwd_after", 32'(bus.fwd_valid), 32'd0);
    tick();

    // Backpressure with three back-to-back entries
    cyc(1, 1, 1, 0, 16'h1111, 0, 0, 0, 0, 0);
    cyc(1, 1, 2, 0, 16'h2222, 0, 0, 0, 0, 0);
    drive(1, 1, 6, 0, 16'h3333, 0, 0, 0, 0, 0);
    chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
    chk("t2_hold_dest", 32'(bus.rf_dest), 32'd1);
    tick();
    drive(1, 1, 6, 0, 16'h3333, 0, 0, 1, 0, 0);
    chk("t2_w1", 32'(bus.rf_dest), 32'd1);
    tick();
    drive(1, 1, 6, 0, 16'h3333, 0, 0, 1, 0, 0);
    chk("t2_w2", 32'(bus.rf_dest), 32'd2);
    chk("t2_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t2_w3", 32'(bus.rf_dest), 32'd6);
    tick();
    idle(1, 2);

    // Register-0 write is dropped and drains without rf_ready
    cyc(1, 1, 0, 1, 0, 16'hAAAA, 0, 0, 0, 0);
    cyc(1, 1, 5, 0, 16'hBEEF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_we", 32'(bus.rf_we), 32'd1);
    chk("t3_dest", 32'(bus.rf_dest), 32'd5);
    chk("t3_fwd_dest", 32'(bus.fwd_dest), 32'd5);
    chk("t3_fwd_data", 32'(bus.fwd_data), 32'hBEEF);
    tick();
    idle(1, 2);

    // Flush with two pending writes
    cyc(1, 1, 2, 0, 16'h0202, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 16'h0404, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_flush_we", 32'(bus.rf_we), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    chk("t4_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle(1, 3);

    // Out-of-range select, then reset over two pending entries
    cyc(1, 1, 7, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    drive(1, 1, 6, 2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    chk("t5_sel_oob", 32'(bus.rf_data), 32'h0000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("t5_rst_we", 32'(bus.rf_we), 32'd0);
    chk("t5_rst_dest", 32'(bus.rf_dest), 32'd0);
    chk("t5_rst_fwd", 32'(bus.fwd_valid), 32'd0);
    chk("t5_rst_fwd_data", 32'(bus.fwd_data), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready), 32'd0);
    tick();
    idle(1, 3);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          16'($urandom), 16'($urandom), 16'($urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 2));
    end
    idle(1, 6);
    chk("drain_writes", 32'(exp_wr.size()), 32'd0);
    chk("drain_entries", 32'(mb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
